// File: rtl/dual_pixel_framer_fp16.sv
// Purpose: pair two 8-bit pixel streams, convert each to FP16 and tag raster col/row (optional SOF realign: DUAL_PIXEL_FRAMER_SOF_SYNC_EN).
// Latency: 2 cycles from acceptance of the later partner to valid_o, with no older pairs queued.
// Backpressure: per-stream ready drops only when that stream's FIFO is full; the output side has none.

// Purpose: show-ahead FIFO, power-of-two depth.
// Latency: pushed entry visible at head the cycle after the push.
// Backpressure: caller must not push when full or pop when empty.
module pair_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign head_dat = mem[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
endmodule

module dual_pixel_framer_fp16 #(
  parameter int IMAGE_WIDTH     = 640,
  parameter int IMAGE_HEIGHT    = 480,
  parameter int PAIR_FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  a_data_i,
  input  logic        a_sof_i,
  input  logic        a_valid_i,
  output logic        a_ready_o,
  input  logic [7:0]  t_data_i,
  input  logic        t_sof_i,
  input  logic        t_valid_i,
  output logic        t_ready_o,
  output logic [15:0] i_a_o,
  output logic [15:0] i_t_o,
  output logic [15:0] col_o,
  output logic [15:0] row_o,
  output logic        valid_o,
  output logic        eof_o
);
`ifdef DUAL_PIXEL_FRAMER_SOF_SYNC_EN
  localparam int EW = 9;
`else
  localparam int EW = 8;
`endif
  localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMAGE_HEIGHT - 1);

  logic [EW-1:0] a_push_dat, t_push_dat, a_head, t_head;
  logic a_empty, a_full, t_empty, t_full;
  logic a_push, t_push, pair_pop;
  logic [15:0] col_cnt, row_cnt, emit_col, emit_row, next_col, next_row;
  logic emit_eof;

`ifdef DUAL_PIXEL_FRAMER_SOF_SYNC_EN
  assign a_push_dat = {a_sof_i, a_data_i};
  assign t_push_dat = {t_sof_i, t_data_i};
`else
  logic unused_sof;
  assign unused_sof = a_sof_i ^ t_sof_i;
  assign a_push_dat = a_data_i;
  assign t_push_dat = t_data_i;
`endif

  assign a_ready_o = !rst_i && !a_full;
  assign t_ready_o = !rst_i && !t_full;
  assign a_push    = a_valid_i && a_ready_o;
  assign t_push    = t_valid_i && t_ready_o;
  assign pair_pop  = !a_empty && !t_empty;

  pair_fifo #(.WIDTH(EW), .DEPTH(PAIR_FIFO_DEPTH)) u_a_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push(a_push), .push_dat(a_push_dat),
    .pop(pair_pop), .head_dat(a_head), .empty(a_empty), .full(a_full)
  );

  pair_fifo #(.WIDTH(EW), .DEPTH(PAIR_FIFO_DEPTH)) u_t_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push(t_push), .push_dat(t_push_dat),
    .pop(pair_pop), .head_dat(t_head), .empty(t_empty), .full(t_full)
  );

  // Every u8 is exactly representable: the value is normalised so its MSB becomes the hidden bit.
  function automatic logic [15:0] to_fp16(input logic [7:0] v);
    logic [2:0]  p;
    logic [10:0] sh;
    p = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) p = 3'(i);
    sh = 11'(v) << (4'd10 - 4'(p));
    to_fp16 = (v == 8'd0) ? 16'h0000 : {1'b0, 5'd15 + 5'(p), sh[9:0]};
  endfunction

  always_comb begin
    emit_col = col_cnt;
    emit_row = row_cnt;
`ifdef DUAL_PIXEL_FRAMER_SOF_SYNC_EN
    if (a_head[8] || t_head[8]) begin
      emit_col = 16'd0;
      emit_row = 16'd0;
    end
`endif
    if (emit_col == LAST_COL) begin
      next_col = 16'd0;
      next_row = (emit_row == LAST_ROW) ? 16'd0 : emit_row + 16'd1;
    end else begin
      next_col = emit_col + 16'd1;
      next_row = emit_row;
    end
    emit_eof = (emit_col == LAST_COL) && (emit_row == LAST_ROW);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_cnt <= '0;
      row_cnt <= '0;
      i_a_o   <= '0;
      i_t_o   <= '0;
      col_o   <= '0;
      row_o   <= '0;
      valid_o <= 1'b0;
      eof_o   <= 1'b0;
    end else begin
      valid_o <= pair_pop;
      if (pair_pop) begin
        col_cnt <= next_col;
        row_cnt <= next_row;
        i_a_o   <= to_fp16(a_head[7:0]);
        i_t_o   <= to_fp16(t_head[7:0]);
        col_o   <= emit_col;
        row_o   <= emit_row;
        eof_o   <= emit_eof;
      end
    end
  end
endmodule

// File: tb/tb_dual_pixel_framer_fp16.sv
// Bench for dual_pixel_framer_fp16: directed and random stimulus against a queue-level pairing model.
module tb_dual_pixel_framer_fp16;
  localparam int W = 4;
  localparam int H = 2;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] a_data, t_data;
  logic a_sof, t_sof, a_valid, t_valid, a_ready, t_ready;
  logic [15:0] i_a, i_t, col, row;
  logic valid, eof;

  int total = 0;
  int bad = 0;

  logic [8:0] qa[$];
  logic [8:0] qt[$];
  int pair_idx = 0;
  logic [15:0] exp_ia, exp_it, exp_col, exp_row;
  logic exp_valid, exp_eof;

  always #5 clk = ~clk;

  dual_pixel_framer_fp16 #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PAIR_FIFO_DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_data_i(a_data), .a_sof_i(a_sof), .a_valid_i(a_valid), .a_ready_o(a_ready),
    .t_data_i(t_data), .t_sof_i(t_sof), .t_valid_i(t_valid), .t_ready_o(t_ready),
    .i_a_o(i_a), .i_t_o(i_t), .col_o(col), .row_o(row), .valid_o(valid), .eof_o(eof)
  );

  // FP16 from plain arithmetic: v = 2^p * (1 + frac/1024).
  function automatic logic [15:0] ref_fp16(input int v);
    int p;
    int frac;
    if (v == 0) return 16'h0000;
    p = 0;
    while ((1 << (p + 1)) <= v) p++;
    frac = (v * 1024) / (1 << p) - 1024;
    return {1'b0, 5'(15 + p), 10'(frac)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic r, input logic av, input logic [7:0] ad, input logic as_,
                      input logic tv, input logic [7:0] td, input logic ts);
    logic acc_a, acc_t, pop_now;
    logic [8:0] ea, et;
    rst = r; a_valid = av; a_data = ad; a_sof = as_;
    t_valid = tv; t_data = td; t_sof = ts;
    #1;
    chk("a_ready", {15'd0, a_ready}, {15'd0, !r && (qa.size() < D)});
    chk("t_ready", {15'd0, t_ready}, {15'd0, !r && (qt.size() < D)});
    acc_a   = av && !r && (qa.size() < D);
    acc_t   = tv && !r && (qt.size() < D);
    pop_now = (qa.size() > 0) && (qt.size() > 0);
    @(posedge clk);
    if (r) begin
      qa.delete(); qt.delete();
      pair_idx = 0;
      exp_ia = 0; exp_it = 0; exp_col = 0; exp_row = 0; exp_valid = 0; exp_eof = 0;
    end else begin
      exp_valid = 1'b0;
      if (pop_now) begin
        ea = qa.pop_front();
        et = qt.pop_front();
`ifdef DUAL_PIXEL_FRAMER_SOF_SYNC_EN
        if (ea[8] || et[8]) pair_idx = 0;
`endif
        exp_col   = 16'(pair_idx % W);
        exp_row   = 16'((pair_idx / W) % H);
        exp_eof   = (exp_col == 16'(W - 1)) && (exp_row == 16'(H - 1));
        exp_ia    = ref_fp16(int'(ea[7:0]));
        exp_it    = ref_fp16(int'(et[7:0]));
        exp_valid = 1'b1;
        pair_idx++;
      end
      if (acc_a) qa.push_back({as_, ad});
      if (acc_t) qt.push_back({ts, td});
    end
    @(negedge clk);
    chk("valid_o", {15'd0, valid}, {15'd0, exp_valid});
    chk("eof_o",   {15'd0, eof},   {15'd0, exp_eof});
    chk("i_a_o", i_a, exp_ia);
    chk("i_t_o", i_t, exp_it);
    chk("col_o", col, exp_col);
    chk("row_o", row, exp_row);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 8'd0, 0, 0, 8'd0, 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 8'd0, 0, 0, 8'd0, 0);
  endtask

  initial begin
    logic [7:0] sweep [4];
    rst = 1'b1; a_valid = 0; t_valid = 0; a_data = 0; t_data = 0; a_sof = 0; t_sof = 0;
    sweep[0] = 8'd0; sweep[1] = 8'd2; sweep[2] = 8'd128; sweep[3] = 8'd3;
    @(negedge clk);

    // Reset state
    do_reset(3);

    // First pair: accepted together, valid two edges later
    tick(0, 1, 8'd1, 0, 1, 8'd255, 0);
    chk("lat_early", {15'd0, valid}, 16'd0);
    tick(0, 0, 8'd0, 0, 0, 8'd0, 0);
    chk("lit_ia_1", i_a, 16'h3C00);
    chk("lit_it_255", i_t, 16'h5BF8);
    idle(2);
    chk("hold_ia", i_a, 16'h3C00);

    // Conversion sweep, back-to-back
    for (int i = 0; i < 4; i++) tick(0, 1, sweep[i], 0, 1, sweep[i], 0);
    idle(3);
    chk("lit_ia_3", i_a, 16'h4200);

    // Frame walk: 9 pairs from (0,0), eof on the 8th
    do_reset(1);
    for (int i = 0; i < 9; i++)
      tick(0, 1, 8'($urandom_range(0, 255)), 0, 1, 8'($urandom_range(0, 255)), 0);
    idle(2);
    chk("pair9_col", col, 16'd0);
    chk("pair9_row", row, 16'd0);

    // Skew: A leads until its FIFO fills, then T catches up
    for (int i = 0; i < 6; i++) tick(0, 1, 8'($urandom_range(1, 255)), 0, 0, 8'd0, 0);
    chk("skew_a_rdy_low", {15'd0, a_ready}, 16'd0);
    for (int i = 0; i < 4; i++) tick(0, 0, 8'd0, 0, 1, 8'($urandom_range(0, 255)), 0);
    idle(3);

    // Reset with stale A beats buffered
    for (int i = 0; i < 3; i++) tick(0, 1, 8'd200, 0, 0, 8'd0, 0);
    do_reset(2);
    tick(0, 1, 8'd7, 0, 1, 8'd9, 0);
    idle(2);

    // Random traffic
    for (int i = 0; i < 400; i++)
      tick(0, ($urandom_range(0, 9) < 7), 8'($urandom_range(0, 255)), 0,
              ($urandom_range(0, 9) < 7), 8'($urandom_range(0, 255)), 0);
    idle(6);

`ifdef DUAL_PIXEL_FRAMER_SOF_SYNC_EN
    // SOF on the 3rd A beat restarts the raster
    do_reset(1);
    for (int i = 0; i < 5; i++)
      tick(0, 1, 8'($urandom_range(0, 255)), (i == 2), 1, 8'($urandom_range(0, 255)), 0);
    idle(3);
    chk("sof_last_col", col, 16'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
